// File: rtl/npi_traffic_master.sv
// Self-checking NPI traffic master: writes an address-derived pattern in 4-beat bursts,
// reads it back and compares each beat. Optional macro: NPI_TRAFFIC_LOOP_EN (continuous passes).
module npi_traffic_master #(
    parameter int unsigned C_PIM_DATA_WIDTH = 64,
    parameter logic [31:0] C_BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned C_NUM_BURSTS     = 16
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            PIM_InitDone,
    output logic [31:0]                     PIM_Addr,
    output logic                            PIM_AddrReq,
    input  logic                            PIM_AddrAck,
    output logic                            PIM_RNW,
    output logic [3:0]                      PIM_Size,
    output logic                            PIM_RdModWr,
    output logic [C_PIM_DATA_WIDTH-1:0]     PIM_WrFIFO_Data,
    output logic [C_PIM_DATA_WIDTH/8-1:0]   PIM_WrFIFO_BE,
    output logic                            PIM_WrFIFO_Push,
    output logic                            PIM_WrFIFO_Flush,
    input  logic                            PIM_WrFIFO_Empty,
    input  logic                            PIM_WrFIFO_AlmostFull,
    input  logic [C_PIM_DATA_WIDTH-1:0]     PIM_RdFIFO_Data,
    output logic                            PIM_RdFIFO_Pop,
    output logic                            PIM_RdFIFO_Flush,
    input  logic                            PIM_RdFIFO_Empty,
    input  logic [1:0]                      PIM_RdFIFO_Latency,
    input  logic [3:0]                      PIM_RdFIFO_RdWdAddr,
    output logic                            Done,
    output logic                            Error,
    output logic [15:0]                     ErrCount
);

    localparam logic [7:0] LastBurst = 8'(C_NUM_BURSTS - 1);

    typedef enum logic [2:0] {
        StIdle, StWFill, StWReq, StWDrain, StRReq, StRData, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  burst_q, burst_d;
    logic [1:0]  wbeat_q, wbeat_d;
    logic [2:0]  pop_cnt_q, pop_cnt_d;
    logic [1:0]  cmp_cnt_q, cmp_cnt_d;
    logic [1:0]  lat_q, lat_d;
    logic        p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
    logic [63:0] p1_dat_q, p1_dat_d, p2_dat_q, p2_dat_d;
    logic        error_q, error_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        pass_q, pass_d;
    logic        flush_q;

    logic [31:0] burst_addr;
    logic [63:0] exp_data;
    logic        cmp_vld;
    logic [63:0] cmp_dat;
    logic        mismatch;
    logic        unused_rdwdaddr;

    function automatic logic [63:0] beat_pattern(input logic [31:0] base, input logic [1:0] beat,
                                                 input logic invert);
        logic [31:0] a;
        a = base + {27'd0, beat, 3'd0};
        return {~a, a} ^ {64{invert}};
    endfunction

    assign unused_rdwdaddr  = ^PIM_RdFIFO_RdWdAddr;
    assign PIM_Size         = 4'h2;
    assign PIM_RdModWr      = 1'b0;
    assign PIM_WrFIFO_BE    = '1;
    assign PIM_WrFIFO_Flush = flush_q;
    assign PIM_RdFIFO_Flush = flush_q;
    assign Error            = error_q;
    assign ErrCount         = err_cnt_q;

    assign burst_addr     = C_BASE_ADDR + {19'd0, burst_q, 5'd0};
    assign PIM_RdFIFO_Pop = (state_q == StRData) && !PIM_RdFIFO_Empty && !pop_cnt_q[2];
    assign exp_data       = beat_pattern(burst_addr, pop_cnt_q[1:0], pass_q);

    // The compare tap follows the latency sampled when this burst's request was issued.
    always_comb begin
        cmp_vld = 1'b0;
        cmp_dat = '0;
        case (lat_q)
            2'd0: begin
                cmp_vld = PIM_RdFIFO_Pop;
                cmp_dat = exp_data;
            end
            2'd1: begin
                cmp_vld = p1_vld_q;
                cmp_dat = p1_dat_q;
            end
            default: begin
                cmp_vld = p2_vld_q;
                cmp_dat = p2_dat_q;
            end
        endcase
    end

    assign mismatch = cmp_vld && (cmp_dat != 64'(PIM_RdFIFO_Data));

    always_comb begin
        state_d         = state_q;
        burst_d         = burst_q;
        wbeat_d         = wbeat_q;
        pop_cnt_d       = pop_cnt_q;
        cmp_cnt_d       = cmp_cnt_q;
        lat_d           = lat_q;
        pass_d          = pass_q;
        p1_vld_d        = 1'b0;
        p1_dat_d        = p1_dat_q;
        p2_vld_d        = 1'b0;
        p2_dat_d        = p2_dat_q;
        error_d         = error_q;
        err_cnt_d       = err_cnt_q;
        PIM_Addr        = '0;
        PIM_AddrReq     = 1'b0;
        PIM_RNW         = 1'b0;
        PIM_WrFIFO_Push = 1'b0;
        PIM_WrFIFO_Data = '0;
        Done            = 1'b0;

        if (mismatch) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (PIM_InitDone) begin
                    state_d = StWFill;
                    burst_d = '0;
                    wbeat_d = '0;
                end
            end
            StWFill: begin
                PIM_WrFIFO_Data = C_PIM_DATA_WIDTH'(beat_pattern(burst_addr, wbeat_q, pass_q));
                if (!PIM_WrFIFO_AlmostFull) begin
                    PIM_WrFIFO_Push = 1'b1;
                    wbeat_d         = wbeat_q + 2'd1;
                    if (wbeat_q == 2'd3) begin
                        state_d = StWReq;
                    end
                end
            end
            StWReq: begin
                PIM_AddrReq = 1'b1;
                PIM_Addr    = burst_addr;
                if (PIM_AddrAck) begin
                    if (burst_q == LastBurst) begin
                        state_d = StWDrain;
                    end else begin
                        burst_d = burst_q + 8'd1;
                        state_d = StWFill;
                    end
                end
            end
            StWDrain: begin
                if (PIM_WrFIFO_Empty) begin
                    state_d = StRReq;
                    burst_d = '0;
                    lat_d   = PIM_RdFIFO_Latency;
                end
            end
            StRReq: begin
                PIM_AddrReq = 1'b1;
                PIM_RNW     = 1'b1;
                PIM_Addr    = burst_addr;
                if (PIM_AddrAck) begin
                    state_d   = StRData;
                    pop_cnt_d = '0;
                    cmp_cnt_d = '0;
                end
            end
            StRData: begin
                p1_vld_d = PIM_RdFIFO_Pop;
                p1_dat_d = exp_data;
                p2_vld_d = p1_vld_q;
                p2_dat_d = p1_dat_q;
                if (PIM_RdFIFO_Pop) begin
                    pop_cnt_d = pop_cnt_q + 3'd1;
                end
                if (cmp_vld) begin
                    cmp_cnt_d = cmp_cnt_q + 2'd1;
                    if (cmp_cnt_q == 2'd3) begin
                        if (burst_q == LastBurst) begin
                            state_d = StDone;
                        end else begin
                            burst_d = burst_q + 8'd1;
                            state_d = StRReq;
                            lat_d   = PIM_RdFIFO_Latency;
                        end
                    end
                end
            end
            StDone: begin
                Done = 1'b1;
`ifdef NPI_TRAFFIC_LOOP_EN
                state_d = StWFill;
                burst_d = '0;
                wbeat_d = '0;
                pass_d  = ~pass_q;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= StIdle;
            burst_q   <= '0;
            wbeat_q   <= '0;
            pop_cnt_q <= '0;
            cmp_cnt_q <= '0;
            lat_q     <= '0;
            pass_q    <= 1'b0;
            p1_vld_q  <= 1'b0;
            p1_dat_q  <= '0;
            p2_vld_q  <= 1'b0;
            p2_dat_q  <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            flush_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            wbeat_q   <= wbeat_d;
            pop_cnt_q <= pop_cnt_d;
            cmp_cnt_q <= cmp_cnt_d;
            lat_q     <= lat_d;
            pass_q    <= pass_d;
            p1_vld_q  <= p1_vld_d;
            p1_dat_q  <= p1_dat_d;
            p2_vld_q  <= p2_vld_d;
            p2_dat_q  <= p2_dat_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            flush_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_npi_traffic_master.sv
// Directed bench for npi_traffic_master with a small NPI memory model
// (write/read FIFOs, configurable ack delay, read latency and single-beat corruption).
module tb_npi_traffic_master;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        PIM_InitDone = 1'b0;
    logic [31:0] PIM_Addr;
    logic        PIM_AddrReq;
    logic        PIM_AddrAck = 1'b0;
    logic        PIM_RNW;
    logic [3:0]  PIM_Size;
    logic        PIM_RdModWr;
    logic [63:0] PIM_WrFIFO_Data;
    logic [7:0]  PIM_WrFIFO_BE;
    logic        PIM_WrFIFO_Push;
    logic        PIM_WrFIFO_Flush;
    logic        PIM_WrFIFO_Empty = 1'b1;
    logic        PIM_WrFIFO_AlmostFull = 1'b0;
    logic [63:0] PIM_RdFIFO_Data = '0;
    logic        PIM_RdFIFO_Pop;
    logic        PIM_RdFIFO_Flush;
    logic        PIM_RdFIFO_Empty = 1'b1;
    logic [1:0]  PIM_RdFIFO_Latency = 2'd0;
    logic [3:0]  PIM_RdFIFO_RdWdAddr = 4'd0;
    logic        Done;
    logic        Error;
    logic [15:0] ErrCount;

    always #5 Clk = ~Clk;

    npi_traffic_master #(
        .C_PIM_DATA_WIDTH(64),
        .C_BASE_ADDR     (32'h0000_0000),
        .C_NUM_BURSTS    (16)
    ) dut (
        .Clk                  (Clk),
        .Rst                  (Rst),
        .PIM_InitDone         (PIM_InitDone),
        .PIM_Addr             (PIM_Addr),
        .PIM_AddrReq          (PIM_AddrReq),
        .PIM_AddrAck          (PIM_AddrAck),
        .PIM_RNW              (PIM_RNW),
        .PIM_Size             (PIM_Size),
        .PIM_RdModWr          (PIM_RdModWr),
        .PIM_WrFIFO_Data      (PIM_WrFIFO_Data),
        .PIM_WrFIFO_BE        (PIM_WrFIFO_BE),
        .PIM_WrFIFO_Push      (PIM_WrFIFO_Push),
        .PIM_WrFIFO_Flush     (PIM_WrFIFO_Flush),
        .PIM_WrFIFO_Empty     (PIM_WrFIFO_Empty),
        .PIM_WrFIFO_AlmostFull(PIM_WrFIFO_AlmostFull),
        .PIM_RdFIFO_Data      (PIM_RdFIFO_Data),
        .PIM_RdFIFO_Pop       (PIM_RdFIFO_Pop),
        .PIM_RdFIFO_Flush     (PIM_RdFIFO_Flush),
        .PIM_RdFIFO_Empty     (PIM_RdFIFO_Empty),
        .PIM_RdFIFO_Latency   (PIM_RdFIFO_Latency),
        .PIM_RdFIFO_RdWdAddr  (PIM_RdFIFO_RdWdAddr),
        .Done                 (Done),
        .Error                (Error),
        .ErrCount             (ErrCount)
    );

    // Stimulus-owned configuration
    int          ack_delay = 5;
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'h28;
    logic        log_en = 1'b1;

    // Model state
    logic [63:0] wq[$];
    logic [63:0] rq[$];
    logic [63:0] mem[logic [31:0]];
    logic [63:0] push_log[$];
    logic [63:0] popped = '0;
    logic        popped_vld = 1'b0;
    logic [63:0] d1 = '0, d2 = '0;
    int          req_cnt = 0, cur_len = 0;
    logic        req_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_rnw = 1'b0;
    int          unstable = 0, bad_len = 0, af_bad = 0, pops_total = 0;
    logic        first_cap = 1'b0;
    logic [31:0] first_addr = '1;
    logic        first_rnw = 1'b1;
    logic [3:0]  first_size = '0;
    logic [7:0]  first_be = '0;

    int n_checks = 0, n_pass = 0, n_fail = 0;

    // Observe the DUT at the active edge (pre-update values); model state only.
    always @(posedge Clk) begin
        if (Rst) begin
            wq.delete();
            rq.delete();
            popped_vld = 1'b0;
            req_cnt    = 0;
            cur_len    = 0;
            req_prev   = 1'b0;
            pops_total = 0;
        end else begin
            if (PIM_WrFIFO_Push) begin
                wq.push_back(PIM_WrFIFO_Data);
                if (PIM_WrFIFO_AlmostFull) af_bad++;
                if (log_en) begin
                    if (push_log.size() == 0) first_be = PIM_WrFIFO_BE;
                    push_log.push_back(PIM_WrFIFO_Data);
                end
            end
            if (PIM_RdFIFO_Pop && rq.size() != 0) begin
                popped     = rq.pop_front();
                popped_vld = 1'b1;
                pops_total++;
            end
            if (PIM_AddrReq) begin
                if (req_prev && (PIM_Addr != prev_addr || PIM_RNW != prev_rnw)) unstable++;
                if (!first_cap && log_en) begin
                    first_cap  = 1'b1;
                    first_addr = PIM_Addr;
                    first_rnw  = PIM_RNW;
                    first_size = PIM_Size;
                end
                cur_len++;
                prev_addr = PIM_Addr;
                prev_rnw  = PIM_RNW;
            end else if (req_prev) begin
                if (cur_len != ack_delay + 1) bad_len++;
                cur_len = 0;
            end
            req_prev = PIM_AddrReq;
            if (PIM_AddrReq && PIM_AddrAck) begin
                req_cnt = 0;
                for (int i = 0; i < 4; i++) begin
                    logic [31:0] a;
                    logic [63:0] v;
                    a = PIM_Addr + 32'(8 * i);
                    if (!PIM_RNW) begin
                        if (wq.size() != 0) mem[a] = wq.pop_front();
                    end else begin
                        v = mem.exists(a) ? mem[a] : 64'd0;
                        if (corrupt_en && a == corrupt_addr) v = v ^ 64'h1;
                        rq.push_back(v);
                    end
                end
            end else if (PIM_AddrReq) begin
                req_cnt++;
            end
        end
    end

    // Drive DUT inputs mid-cycle, away from the sampling edge.
    always @(negedge Clk) begin
        if (Rst) begin
            d1 = '0;
            d2 = '0;
            PIM_AddrAck = 1'b0;
        end else begin
            d2 = d1;
            d1 = popped_vld ? popped : 64'd0;
            popped_vld = 1'b0;
            PIM_AddrAck = PIM_AddrReq && (req_cnt >= ack_delay);
        end
        PIM_WrFIFO_Empty = (wq.size() == 0);
        PIM_RdFIFO_Empty = (rq.size() == 0);
        case (PIM_RdFIFO_Latency)
            2'd0:    PIM_RdFIFO_Data = (rq.size() != 0) ? rq[0] : 64'd0;
            2'd1:    PIM_RdFIFO_Data = d1;
            default: PIM_RdFIFO_Data = d2;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!Done && i < 3000) begin
            tick();
            i++;
        end
        check(tag, {63'd0, Done}, 64'd1);
    endtask

    task automatic restart(input logic [1:0] lat, input int delay);
        Rst = 1'b1;
        repeat (2) tick();
        PIM_RdFIFO_Latency = lat;
        ack_delay = delay;
        Rst = 1'b0;
    endtask

    initial begin
        int idle_bad;
        int seq_bad;
        int i;

        // Reset held 16 cycles
        repeat (16) tick();
        check("rst_addrreq", {63'd0, PIM_AddrReq}, 64'd0);
        check("rst_push", {63'd0, PIM_WrFIFO_Push}, 64'd0);
        check("rst_pop", {63'd0, PIM_RdFIFO_Pop}, 64'd0);
        check("rst_wrflush", {63'd0, PIM_WrFIFO_Flush}, 64'd1);
        check("rst_rdflush", {63'd0, PIM_RdFIFO_Flush}, 64'd1);
        check("rst_addr", {32'd0, PIM_Addr}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_error", {63'd0, Error}, 64'd0);
        check("rst_errcount", {48'd0, ErrCount}, 64'd0);

        // Release, InitDone low for 100 cycles
        Rst = 1'b0;
        tick();
        check("flush_release", {62'd0, PIM_WrFIFO_Flush, PIM_RdFIFO_Flush}, 64'd0);
        idle_bad = 0;
        repeat (100) begin
            tick();
            if (PIM_AddrReq || PIM_WrFIFO_Push || PIM_WrFIFO_Flush || PIM_RdFIFO_Flush)
                idle_bad++;
        end
        check("idle_activity", 64'(idle_bad), 64'd0);
        check("idle_no_push", 64'(push_log.size()), 64'd0);

        // Run 1: ack delay 5, latency 0, AlmostFull stall after beat 1
        PIM_InitDone = 1'b1;
        i = 0;
        while (push_log.size() < 2 && i < 50) begin
            tick();
            i++;
        end
        PIM_WrFIFO_AlmostFull = 1'b1;
        repeat (3) tick();
        PIM_WrFIFO_AlmostFull = 1'b0;
        wait_done("run1_done");
        check("run1_error", {63'd0, Error}, 64'd0);
        check("run1_errcount", {48'd0, ErrCount}, 64'd0);
        check("af_push", 64'(af_bad), 64'd0);
        check("push_count", 64'(push_log.size()), 64'd64);
        check("push0", (push_log.size() > 0) ? push_log[0] : 64'd0, 64'hFFFFFFFF_00000000);
        check("push1", (push_log.size() > 1) ? push_log[1] : 64'd0, 64'hFFFFFFF7_00000008);
        seq_bad = 0;
        for (int k = 0; k < push_log.size(); k++) begin
            logic [31:0] a;
            a = 32'(8 * k);
            if (push_log[k] !== {~a, a}) seq_bad++;
        end
        check("push_sequence", 64'(seq_bad), 64'd0);
        check("first_req_addr", {32'd0, first_addr}, 64'd0);
        check("first_req_rnw", {63'd0, first_rnw}, 64'd0);
        check("first_req_size", {60'd0, first_size}, 64'd2);
        check("first_be", {56'd0, first_be}, 64'hFF);
        check("req_stable", 64'(unstable), 64'd0);
        check("req_len", 64'(bad_len), 64'd0);
        repeat (10) tick();
        check("done_held", {63'd0, Done}, 64'd1);

        // Runs 2 and 3: read latency 1 and 2, immediate ack
        log_en = 1'b0;
        restart(2'd1, 0);
        wait_done("lat1_done");
        check("lat1_errcount", {48'd0, ErrCount}, 64'd0);
        restart(2'd2, 0);
        wait_done("lat2_done");
        check("lat2_errcount", {48'd0, ErrCount}, 64'd0);
        check("lat_req_len", 64'(bad_len), 64'd0);

        // Run 4: one corrupted beat at 0x28
        corrupt_en = 1'b1;
        restart(2'd1, 0);
        wait_done("corrupt_done");
        check("corrupt_error", {63'd0, Error}, 64'd1);
        check("corrupt_errcount", {48'd0, ErrCount}, 64'd1);

        // Run 5: reset during RDATA of burst 3, then clean rerun
        restart(2'd2, 0);
        i = 0;
        while (pops_total < 13 && i < 3000) begin
            tick();
            i++;
        end
        check("mid_reached_rdata", {63'd0, PIM_RdFIFO_Pop | (pops_total >= 13)}, 64'd1);
        check("mid_error_before", {63'd0, Error}, 64'd1);
        Rst = 1'b1;
        tick();
        check("mid_addrreq", {63'd0, PIM_AddrReq}, 64'd0);
        check("mid_pop", {63'd0, PIM_RdFIFO_Pop}, 64'd0);
        check("mid_push", {63'd0, PIM_WrFIFO_Push}, 64'd0);
        check("mid_flushes", {62'd0, PIM_WrFIFO_Flush, PIM_RdFIFO_Flush}, 64'd3);
        check("mid_done", {63'd0, Done}, 64'd0);
        check("mid_error", {63'd0, Error}, 64'd0);
        check("mid_errcount", {48'd0, ErrCount}, 64'd0);
        corrupt_en = 1'b0;
        tick();
        Rst = 1'b0;
        tick();
        check("rerun_flush_low", {62'd0, PIM_WrFIFO_Flush, PIM_RdFIFO_Flush}, 64'd0);
        wait_done("rerun_done");
        check("rerun_error", {63'd0, Error}, 64'd0);
        check("rerun_errcount", {48'd0, ErrCount}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/npi_traffic_master.md
Name: npi_traffic_master

Overview:
- Self-checking traffic generator that masters one MPMC Native Port Interface (NPI/PIM) port.
- After memory init completes, it writes a deterministic address-derived pattern in 4-beat cache-line bursts. It then reads the same region back and compares every beat.
- Sits between the system reset/clock and a PIM port of the memory-controller subsystem; used for DDR2 bring-up and simulation.

Parameters:
- C_PIM_DATA_WIDTH, 64, NPI data width in bits; only 64 is supported.
- C_BASE_ADDR, 32'h0000_0000, byte address of the first burst; must be 32-byte aligned.
- C_NUM_BURSTS, 16, number of 32-byte bursts written and then read; legal range 1..256.

Ports:
- Clk  in  1  NPI/PIM clock; all logic is on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- PIM_InitDone  in  1  memory controller calibration complete.
- PIM_Addr  out  32  byte address of the request.
- PIM_AddrReq  out  1  address request.
- PIM_AddrAck  in  1  request accepted.
- PIM_RNW  out  1  1 = read, 0 = write.
- PIM_Size  out  4  transfer size code.
- PIM_RdModWr  out  1  read-modify-write; tied 0.
- PIM_WrFIFO_Data  out  64  write data.
- PIM_WrFIFO_BE  out  8  byte enables.
- PIM_WrFIFO_Push  out  1  push write data.
- PIM_WrFIFO_Flush  out  1  flush write FIFO.
- PIM_WrFIFO_Empty  in  1  write FIFO empty.
- PIM_WrFIFO_AlmostFull  in  1  write FIFO almost full.
- PIM_RdFIFO_Data  in  64  read data.
- PIM_RdFIFO_Pop  out  1  pop read FIFO.
- PIM_RdFIFO_Flush  out  1  flush read FIFO.
- PIM_RdFIFO_Empty  in  1  read FIFO empty.
- PIM_RdFIFO_Latency  in  2  pop-to-data latency (0, 1 or 2 cycles).
- PIM_RdFIFO_RdWdAddr  in  4  word address within burst; ignored.
- Done  out  1  test finished.
- Error  out  1  sticky: at least one compare mismatch.
- ErrCount  out  16  number of mismatching beats; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - all outputs 0, except PIM_WrFIFO_Flush = 1 and PIM_RdFIFO_Flush = 1 while Rst is high.
  - Flushes deassert on the first cycle after Rst falls.
  - Internal burst counter, beat counter and error state are cleared.
- Constant outputs:
  - PIM_Size = 4'h2 (8×32-bit cache line = four 64-bit beats).
  - PIM_RdModWr = 0.
  - PIM_WrFIFO_BE = 8'hFF.
- Pattern: the beat at byte address A (A = burst address + 8×beat) has data {~A, A}, i.e. upper 32 bits = ~A, lower 32 bits = A.
- States:
  - IDLE: wait for PIM_InitDone = 1, then go to WFILL with burst index n = 0.
  - WFILL:
    - Push beats 0..3 of burst n, one per cycle, only while PIM_WrFIFO_AlmostFull = 0.
    - When AlmostFull = 1, Push = 0 and the beat is held.
    - After beat 3 is pushed, go to WREQ.
  - WREQ:
    - AddrReq = 1, RNW = 0, Addr = C_BASE_ADDR + 32×n; hold all stable until the AddrAck cycle.
    - On AddrAck, AddrReq drops the next cycle.
    - If n = C_NUM_BURSTS−1, go to WDRAIN; otherwise n++ and return to WFILL.
  - WDRAIN: wait for PIM_WrFIFO_Empty = 1, then go to RREQ with n = 0.
  - RREQ: AddrReq = 1, RNW = 1, Addr = C_BASE_ADDR + 32×n; on AddrAck go to RDATA.
  - RDATA:
    - Pop = 1 whenever RdFIFO_Empty = 0 and fewer than 4 beats of this burst have been popped.
    - Each pop enqueues its expected beat into a delay pipe of depth PIM_RdFIFO_Latency.
    - When the pipe emits, compare against PIM_RdFIFO_Data; a mismatch sets Error and increments ErrCount.
    - After the 4th compare, advance: n++ and go to RREQ, or go to DONE after the last burst.
  - DONE: Done = 1; the block stays here until Rst.
- Only one request is outstanding at a time; no new AddrReq is issued before the previous burst's data has fully completed.
- PIM_RdFIFO_Latency is sampled once on entry to RREQ and held for that burst.
- Rst mid-operation: the block returns to IDLE next cycle, drops any asserted AddrReq/Push/Pop, flushes both FIFOs for the reset duration, and clears Done/Error/ErrCount.
- Address arithmetic is 32-bit and wraps silently.

Optional Feature:
- Macro NPI_TRAFFIC_LOOP_EN.
  - Defined: DONE is a one-cycle pulse state; the block then returns to WFILL with n = 0 and the pattern inverted on alternate passes (data XOR 64'hFFFF_FFFF_FFFF_FFFF on odd passes). Error and ErrCount accumulate across passes; Done pulses once per pass.
  - Undefined: single pass, Done is held high.

Test Plan:
- Reset held 16 cycles, then InitDone stays 0 for 100 cycles -> no AddrReq or Push, both Flushes high only during reset.
- InitDone = 1, C_BASE_ADDR = 0, ideal memory -> first pushes are 64'hFFFFFFFF_00000000, FFFFFFF7_00000008, …; first AddrReq has Addr = 0, RNW = 0, Size = 2; Done = 1, Error = 0, ErrCount = 0.
- AddrAck delayed 5 cycles -> AddrReq and Addr held stable for all 6 cycles and deassert the cycle after the ack.
- WrFIFO_AlmostFull forced high for 3 cycles mid-burst -> no Push during those cycles; beat sequence unchanged.
- Read with RdFIFO_Latency = 0, 1 and 2 -> zero errors for each; corrupting one beat at address 0x28 gives Error = 1, ErrCount = 1.
- Rst pulsed during RDATA -> outputs return to reset values; the full sequence reruns and completes cleanly.
